// File: rtl/gpio_controller_v2_if.sv
// Peripheral bus bundle for gpio_controller_v2: word address, write data/strobe and registered read data.
interface gpio_controller_v2_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] AddressBus_P;
  logic [31:0]       DataWriteBus_P;
  logic              WriteAssert_P;
  logic [31:0]       DataReadBus_p;

  modport master (
    output AddressBus_P,
    output DataWriteBus_P,
    output WriteAssert_P,
    input  DataReadBus_p
  );

  modport slave (
    input  AddressBus_P,
    input  DataWriteBus_P,
    input  WriteAssert_P,
    output DataReadBus_p
  );
endinterface

// File: rtl/gpio_controller_v2.sv
// Parametrised GPIO: outputs with atomic set/clear, hex register, synchronised+debounced inputs, sticky edge capture, level Irq.
// Optional falling-edge capture (idx 8/9) is enabled by defining GPIO_FALLING_EDGE_EN.
module gpio_controller_v2 #(
  parameter int unsigned          NUM_OUT         = 18,
  parameter int unsigned          NUM_IN          = 14,
  parameter int unsigned          HEX_W           = 16,
  parameter int unsigned          ADDR_W          = 14,
  parameter logic [ADDR_W-1:0]    BASE_ADDR       = 14'h0000,
  parameter int unsigned          DEBOUNCE_CYCLES = 50000
) (
  input  logic                    CoreClock,
  input  logic                    CoreReset_n,
  gpio_controller_v2_if.slave     bus,
  output logic                    Irq,
  output logic [NUM_OUT-1:0]      GpioOut,
  output logic [HEX_W-1:0]        HexOut,
  input  logic [NUM_IN-1:0]       GpioIn
);

  localparam int unsigned     PW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] IDX_OUT_DATA    = 4'd0;
  localparam logic [3:0] IDX_OUT_SET     = 4'd1;
  localparam logic [3:0] IDX_OUT_CLR     = 4'd2;
  localparam logic [3:0] IDX_HEX         = 4'd3;
  localparam logic [3:0] IDX_IN_SYNC     = 4'd4;
  localparam logic [3:0] IDX_IN_DEB      = 4'd5;
  localparam logic [3:0] IDX_RISE_STATUS = 4'd6;
  localparam logic [3:0] IDX_RISE_MASK   = 4'd7;
`ifdef GPIO_FALLING_EDGE_EN
  localparam logic [3:0] IDX_FALL_STATUS = 4'd8;
  localparam logic [3:0] IDX_FALL_MASK   = 4'd9;
`endif

  logic                    sel_s;
  logic [3:0]              idx_s;
  logic                    wr_s;
  logic [31:0]             wdata_s;
  logic                    unused_wdata_s;

  logic [NUM_OUT-1:0]      out_q, out_d;
  logic [HEX_W-1:0]        hex_q, hex_d;
  logic [NUM_IN-1:0]       sync1_q, sync1_d;
  logic [NUM_IN-1:0]       sync2_q, sync2_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick_s;
  logic [NUM_IN-1:0][1:0]  cnt_q, cnt_d;
  logic [NUM_IN-1:0]       deb_q, deb_d;
  logic [NUM_IN-1:0]       rise_s;
  logic [NUM_IN-1:0]       rise_clr_s;
  logic [NUM_IN-1:0]       rise_st_q, rise_st_d;
  logic [NUM_IN-1:0]       rise_mask_q, rise_mask_d;
  logic                    fall_irq_s;
  logic                    irq_q, irq_d;
  logic [31:0]             rdata_q, rdata_d;

`ifdef GPIO_FALLING_EDGE_EN
  logic [NUM_IN-1:0]       fall_s;
  logic [NUM_IN-1:0]       fall_clr_s;
  logic [NUM_IN-1:0]       fall_st_q, fall_st_d;
  logic [NUM_IN-1:0]       fall_mask_q, fall_mask_d;
`endif

  assign sel_s          = (bus.AddressBus_P[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign idx_s          = bus.AddressBus_P[3:0];
  assign wr_s           = sel_s & bus.WriteAssert_P;
  assign wdata_s        = bus.DataWriteBus_P;
  assign unused_wdata_s = ^wdata_s;

  // Input path: two-flop synchroniser, prescaler tick, per-bit 3-tick debounce counter.
  always_comb begin
    sync1_d = GpioIn;
    sync2_d = sync1_q;
    tick_s  = (presc_q == PRESC_MAX);
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (tick_s) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == 2'd2) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = 2'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 2'd1;
          end
        end else begin
          cnt_d[i] = 2'd0;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    // Edge pulses come from the debounced value about to be committed, so status sets with IN_DEB.
    rise_s = deb_d & ~deb_q;
`ifdef GPIO_FALLING_EDGE_EN
    fall_s = deb_q & ~deb_d;
`endif
  end

  // Register writes; sticky status where a same-cycle edge overrides the W1C clear.
  always_comb begin
    out_d       = out_q;
    hex_d       = hex_q;
    rise_mask_d = rise_mask_q;
    rise_clr_s  = '0;
`ifdef GPIO_FALLING_EDGE_EN
    fall_mask_d = fall_mask_q;
    fall_clr_s  = '0;
`endif
    if (wr_s) begin
      case (idx_s)
        IDX_OUT_DATA:    out_d       = wdata_s[NUM_OUT-1:0];
        IDX_OUT_SET:     out_d       = out_q | wdata_s[NUM_OUT-1:0];
        IDX_OUT_CLR:     out_d       = out_q & ~wdata_s[NUM_OUT-1:0];
        IDX_HEX:         hex_d       = wdata_s[HEX_W-1:0];
        IDX_RISE_STATUS: rise_clr_s  = wdata_s[NUM_IN-1:0];
        IDX_RISE_MASK:   rise_mask_d = wdata_s[NUM_IN-1:0];
`ifdef GPIO_FALLING_EDGE_EN
        IDX_FALL_STATUS: fall_clr_s  = wdata_s[NUM_IN-1:0];
        IDX_FALL_MASK:   fall_mask_d = wdata_s[NUM_IN-1:0];
`endif
        default:         out_d       = out_q;
      endcase
    end else begin
      out_d = out_q;
    end
    rise_st_d = (rise_st_q & ~rise_clr_s) | rise_s;
`ifdef GPIO_FALLING_EDGE_EN
    fall_st_d = (fall_st_q & ~fall_clr_s) | fall_s;
`endif
  end

`ifdef GPIO_FALLING_EDGE_EN
  assign fall_irq_s = |(fall_st_q & fall_mask_q);
`else
  assign fall_irq_s = 1'b0;
`endif

  // Read mux sampled every cycle from the live address; interrupt from current status.
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (sel_s) begin
      case (idx_s)
        IDX_OUT_DATA:    rdata_d = 32'(out_q);
        IDX_HEX:         rdata_d = 32'(hex_q);
        IDX_IN_SYNC:     rdata_d = 32'(sync2_q);
        IDX_IN_DEB:      rdata_d = 32'(deb_q);
        IDX_RISE_STATUS: rdata_d = 32'(rise_st_q);
        IDX_RISE_MASK:   rdata_d = 32'(rise_mask_q);
`ifdef GPIO_FALLING_EDGE_EN
        IDX_FALL_STATUS: rdata_d = 32'(fall_st_q);
        IDX_FALL_MASK:   rdata_d = 32'(fall_mask_q);
`endif
        default:         rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
    irq_d = (|(rise_st_q & rise_mask_q)) | fall_irq_s;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      out_q       <= '0;
      hex_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      cnt_q       <= '0;
      deb_q       <= '0;
      rise_st_q   <= '0;
      rise_mask_q <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
`ifdef GPIO_FALLING_EDGE_EN
      fall_st_q   <= '0;
      fall_mask_q <= '0;
`endif
    end else begin
      out_q       <= out_d;
      hex_q       <= hex_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      rise_st_q   <= rise_st_d;
      rise_mask_q <= rise_mask_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
`ifdef GPIO_FALLING_EDGE_EN
      fall_st_q   <= fall_st_d;
      fall_mask_q <= fall_mask_d;
`endif
    end
  end

  assign GpioOut           = out_q;
  assign HexOut            = hex_q;
  assign Irq               = irq_q;
  assign bus.DataReadBus_p = rdata_q;

endmodule

// File: tb/tb_gpio_controller_v2.sv
// Directed self-checking bench for gpio_controller_v2 with a short debounce period (4 cycles per tick).
module tb_gpio_controller_v2;

  logic        clk;
  logic        rst_n;
  logic        irq;
  logic [17:0] gpio_out;
  logic [15:0] hex_out;
  logic [13:0] gpio_in;
  int          checks;
  int          errors;
  int          cyc;

  gpio_controller_v2_if #(.ADDR_W(14)) bus ();

  gpio_controller_v2 #(
    .NUM_OUT(18), .NUM_IN(14), .HEX_W(16), .ADDR_W(14),
    .BASE_ADDR(14'h0000), .DEBOUNCE_CYCLES(4)
  ) dut (
    .CoreClock(clk), .CoreReset_n(rst_n), .bus(bus),
    .Irq(irq), .GpioOut(gpio_out), .HexOut(hex_out), .GpioIn(gpio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the prescaler ticks on edges where this becomes a multiple of 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.AddressBus_P = a; bus.DataWriteBus_P = d; bus.WriteAssert_P = 1'b1;
    @(posedge clk); #1;
    bus.WriteAssert_P = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.AddressBus_P = a;
    @(posedge clk); #1;
    d = bus.DataReadBus_p;
  endtask

  task automatic wait_phase();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cyc % 4 == 0) break;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; gpio_in = 14'h0;
    bus.AddressBus_P = 14'h0; bus.DataWriteBus_P = 32'h0; bus.WriteAssert_P = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    #1;
    checks++; if (gpio_out !== 18'h0) begin errors++; $display("FAIL reset_gpio_out: got %h expected %h", gpio_out, 18'h0); end
    checks++; if (hex_out !== 16'h0) begin errors++; $display("FAIL reset_hex_out: got %h expected %h", hex_out, 16'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (bus.DataReadBus_p !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.DataReadBus_p); end
    rd(14'h0005, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_in_deb: got %h expected 0", d); end
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    wr(14'h0000, 32'hFFFF_FFFF);
    rd(14'h0000, d);
    checks++; if (d !== 32'h0003_FFFF) begin errors++; $display("FAIL out_data_width: got %h expected %h", d, 32'h0003_FFFF); end
    wr(14'h0000, 32'h0000_00F0);
    wr(14'h0001, 32'h0000_0003);
    wr(14'h0002, 32'h0000_0030);
    checks++; if (gpio_out !== 18'h000C3) begin errors++; $display("FAIL set_clear_pins: got %h expected %h", gpio_out, 18'h000C3); end
    rd(14'h0000, d);
    checks++; if (d !== 32'h0000_00C3) begin errors++; $display("FAIL set_clear_read: got %h expected %h", d, 32'h0000_00C3); end
    rd(14'h0001, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL out_set_reads_zero: got %h expected 0", d); end
    rd(14'h0002, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL out_clr_reads_zero: got %h expected 0", d); end
    wr(14'h0003, 32'hABCD_1234);
    checks++; if (hex_out !== 16'h1234) begin errors++; $display("FAIL hex_pins: got %h expected %h", hex_out, 16'h1234); end
    rd(14'h0003, d);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL hex_read: got %h expected %h", d, 32'h0000_1234); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    wr(14'h0010, 32'h0000_FFFF);
    checks++; if (gpio_out !== 18'h000C3) begin errors++; $display("FAIL decode_out_untouched: got %h expected %h", gpio_out, 18'h000C3); end
    checks++; if (hex_out !== 16'h1234) begin errors++; $display("FAIL decode_hex_untouched: got %h expected %h", hex_out, 16'h1234); end
    rd(14'h0010, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL decode_unselected_read: got %h expected 0", d); end
    rd(14'h000E, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL decode_idx_e_read: got %h expected 0", d); end
    wr(14'h0009, 32'h0000_0001);
    rd(14'h0009, d);
`ifdef GPIO_FALLING_EDGE_EN
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fall_mask_read: got %h expected 1", d); end
`else
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL idx9_reads_zero: got %h expected 0", d); end
`endif
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    int n;
    bit seen;
    @(posedge clk); #1; gpio_in[0] = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    gpio_in[0] = 1'b0;
    repeat (30) @(posedge clk);
    rd(14'h0005, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_in_deb: got %h expected 0", d); end
    rd(14'h0006, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_rise_status: got %h expected 0", d); end
    @(posedge clk); #1;
    gpio_in[0] = 1'b1; bus.AddressBus_P = 14'h0005;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; n++;
      if (bus.DataReadBus_p[0] === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || n < 12 || n > 15) begin errors++; $display("FAIL debounce_latency: got seen=%0b after %0d cycles expected 12..15", seen, n); end
    rd(14'h0004, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL in_sync: got %h expected 1", d); end
    rd(14'h0006, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL held_rise_status: got %h expected 1", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic irq_prev;
    bit seen;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
    wr(14'h0006, 32'h0000_0001);
    rd(14'h0006, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h expected 0", d); end
    wr(14'h0007, 32'h0000_0001);
    gpio_in[0] = 1'b0;
    repeat (24) @(posedge clk);
    #1; bus.AddressBus_P = 14'h0006;
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    irq_prev = irq; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.DataReadBus_p[0] === 1'b1) begin seen = 1'b1; break; end
      irq_prev = irq;
    end
    checks++; if (!seen || irq !== 1'b1 || irq_prev !== 1'b0) begin errors++; $display("FAIL irq_rise_timing: got seen=%0b irq=%b prev=%b expected 1,1,0", seen, irq, irq_prev); end
    wr(14'h0006, 32'h0000_0001);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_clear_edge: got %b expected 1", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
  endtask

  task automatic test_collision();
    gpio_in[0] = 1'b0;
    repeat (24) @(posedge clk);
    wait_phase();
    gpio_in[0] = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    bus.AddressBus_P = 14'h0005;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.DataReadBus_p !== 32'h0) begin errors++; $display("FAIL collision_deb_before: got %h expected 0", bus.DataReadBus_p); end
    bus.AddressBus_P = 14'h0006; bus.DataWriteBus_P = 32'h1; bus.WriteAssert_P = 1'b1;
    @(posedge clk); #1;
    bus.WriteAssert_P = 1'b0;
    checks++; if (bus.DataReadBus_p !== 32'h0) begin errors++; $display("FAIL collision_status_before: got %h expected 0", bus.DataReadBus_p); end
    bus.AddressBus_P = 14'h0005;
    @(posedge clk); #1;
    checks++; if (bus.DataReadBus_p !== 32'h1) begin errors++; $display("FAIL collision_deb_after: got %h expected 1", bus.DataReadBus_p); end
    bus.AddressBus_P = 14'h0006;
    @(posedge clk); #1;
    checks++; if (bus.DataReadBus_p !== 32'h1) begin errors++; $display("FAIL collision_set_wins: got %h expected 1", bus.DataReadBus_p); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(14'h0000, 32'h0003_FFFF);
    wait_phase();
    gpio_in[2] = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (bus.DataReadBus_p !== 32'h0003_FFFF || irq !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got rdata=%h irq=%b expected 0003ffff,1", bus.DataReadBus_p, irq); end
    rst_n = 1'b0;
    #2;
    checks++; if (gpio_out !== 18'h0) begin errors++; $display("FAIL async_reset_gpio_out: got %h expected 0", gpio_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
    checks++; if (bus.DataReadBus_p !== 32'h0) begin errors++; $display("FAIL async_reset_rdata: got %h expected 0", bus.DataReadBus_p); end
    checks++; if (hex_out !== 16'h0) begin errors++; $display("FAIL async_reset_hex: got %h expected 0", hex_out); end
    @(posedge clk); #1;
    bus.AddressBus_P = 14'h0005;
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    checks++; if (bus.DataReadBus_p !== 32'h0) begin errors++; $display("FAIL post_reset_deb_early: got %h expected 0", bus.DataReadBus_p); end
    @(posedge clk); #1;
    checks++; if (bus.DataReadBus_p !== 32'h5) begin errors++; $display("FAIL post_reset_deb_3ticks: got %h expected 5", bus.DataReadBus_p); end
    rd(14'h0006, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL post_reset_rise_status: got %h expected 5", d); end
    rd(14'h0007, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_mask: got %h expected 0", d); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_set_clear();
    test_decode();
    test_debounce();
    test_irq();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
